// File: rtl/eu_responder_if.sv
// eu_responder_if: decoder <-> execution-unit dispatch bundle.
// The decoder (master) dispatches an operation with cs_eu/sel_eu and the
// operands. The execution unit (slave) answers with ready_eu, the result,
// a write-enable pulse, the compare flags and a sticky illegal indication.
interface eu_responder_if #(
  parameter int DW = 32
);
  logic          cs_eu;
  logic [1:0]    sel_eu;
  logic [31:0]   ir;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          ready_eu;
  logic [DW-1:0] result;
  logic          result_we;
  logic [1:0]    Flag;
  logic          illegal;

  modport master (
    output cs_eu, sel_eu, ir, op_a, op_b,
    input  ready_eu, result, result_we, Flag, illegal
  );

  modport slave (
    input  cs_eu, sel_eu, ir, op_a, op_b,
    output ready_eu, result, result_we, Flag, illegal
  );
endinterface

// File: rtl/eu_responder.sv
// eu_responder: execution-unit side of the decoder dispatch handshake.
// Executes arith_i / arith / comp classes on DW-bit operands. Single-cycle
// ops return ready_eu two edges after dispatch is sampled; MUL is an
// iterative shift-add taking MUL_CYC extra cycles (MUL_CYC must equal DW).
// Build option: define EU_MUL_EN to include the shift-add multiplier. When
// it is undefined, func=111 is treated as a disabled function (illegal).
module eu_responder #(
  parameter int DW      = 32,
  parameter int MUL_CYC = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  eu_responder_if.slave bus
);

  localparam logic [1:0] SEL_ARITH_I = 2'b00;
  localparam logic [1:0] SEL_ARITH   = 2'b01;
  localparam logic [1:0] SEL_COMP    = 2'b10;
  localparam logic [1:0] SEL_RSVD    = 2'b11;

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SUB = 3'b001;
  localparam logic [2:0] F_AND = 3'b010;
  localparam logic [2:0] F_OR  = 3'b011;
  localparam logic [2:0] F_XOR = 3'b100;
  localparam logic [2:0] F_SHL = 3'b101;
  localparam logic [2:0] F_SHR = 3'b110;
  localparam logic [2:0] F_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
`ifdef EU_MUL_EN
    S_MUL  = 2'b10,
`endif
    S_DONE = 2'b11
  } state_e;

`ifdef EU_MUL_EN
  localparam int CNT_W = $clog2(MUL_CYC);
`else
  localparam int unused_mul_cyc = MUL_CYC;
`endif

  state_e        state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [2:0]    func_q, func_d;
  logic [1:0]    sel_q, sel_d;
  logic [DW-1:0] result_q, result_d;
  logic          we_q, we_d;
  logic          ready_q, ready_d;
  logic [1:0]    flag_q, flag_d;
  logic          illegal_q, illegal_d;
`ifdef EU_MUL_EN
  logic [DW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    acc_sum;
`endif

  // Only the immediate (15:0) and the two func fields of ir are decoded.
  logic unused_ir;
  assign unused_ir = ^{bus.ir[31:21], bus.ir[17:16]};

  // Single-cycle ALU shared by arith_i and arith; MUL is handled elsewhere.
  function automatic logic [DW-1:0] alu(input logic [2:0]    f,
                                        input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    logic [DW-1:0] r;
    unique case (f)
      F_ADD:   r = a + b;
      F_SUB:   r = a - b;
      F_AND:   r = a & b;
      F_OR:    r = a | b;
      F_XOR:   r = a ^ b;
      F_SHL:   r = a << b[4:0];
      F_SHR:   r = a >> b[4:0];
      default: r = a;
    endcase
    return r;
  endfunction

  // Next-state, datapath and registered-output computation for the FSM.
  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    func_d    = func_q;
    sel_d     = sel_q;
    result_d  = result_q;
    we_d      = 1'b0;
    ready_d   = ready_q;
    flag_d    = flag_q;
    illegal_d = illegal_q;
`ifdef EU_MUL_EN
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    acc_sum   = acc_q + (b_q[0] ? a_q : '0);
`endif

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b0;
        // Only a clean 1 dispatches; X/Z fall through as deasserted.
        if (bus.cs_eu == 1'b1) begin
          sel_d   = bus.sel_eu;
          a_d     = bus.op_a;
          func_d  = (bus.sel_eu == SEL_ARITH_I) ? bus.ir[20:18] : bus.ir[2:0];
          b_d     = (bus.sel_eu == SEL_ARITH_I) ?
                    {{(DW-16){bus.ir[15]}}, bus.ir[15:0]} : bus.op_b;
          state_d = S_EXEC;
`ifdef EU_MUL_EN
          // Reserved sel never reaches the multiplier; it is reported in EXEC.
          if (func_d == F_MUL &&
              (bus.sel_eu == SEL_ARITH_I || bus.sel_eu == SEL_ARITH)) begin
            state_d = S_MUL;
            cnt_d   = '0;
            acc_d   = '0;
          end
`endif
        end
      end

      S_EXEC: begin
        state_d = S_DONE;
        ready_d = 1'b1;
        case (sel_q)
          SEL_COMP: flag_d    = {a_q == b_q, $signed(a_q) < $signed(b_q)};
          SEL_RSVD: illegal_d = 1'b1;
          default: begin
            if (func_q == F_MUL) begin
              // Only reachable when the multiplier is compiled out.
              illegal_d = 1'b1;
            end else begin
              result_d = alu(func_q, a_q, b_q);
              we_d     = 1'b1;
            end
          end
        endcase
      end

`ifdef EU_MUL_EN
      S_MUL: begin
        acc_d = acc_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MUL_CYC - 1)) begin
          result_d = acc_sum;
          we_d     = 1'b1;
          ready_d  = 1'b1;
          state_d  = S_DONE;
        end
      end
`endif

      S_DONE: begin
        ready_d = 1'b1;
        if (bus.cs_eu != 1'b1) begin
          ready_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        ready_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      func_q    <= '0;
      sel_q     <= '0;
      result_q  <= '0;
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      flag_q    <= 2'b00;
      illegal_q <= 1'b0;
`ifdef EU_MUL_EN
      acc_q     <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      func_q    <= func_d;
      sel_q     <= sel_d;
      result_q  <= result_d;
      we_q      <= we_d;
      ready_q   <= ready_d;
      flag_q    <= flag_d;
      illegal_q <= illegal_d;
`ifdef EU_MUL_EN
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.ready_eu  = ready_q;
  assign bus.result    = result_q;
  assign bus.result_we = we_q;
  assign bus.Flag      = flag_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_eu_responder.sv
// tb_eu_responder: self-checking bench for eu_responder.
// Directed vector table, randomized ops against a behavioural model, and
// hand sequences for reset abort, MUL / disabled func=111 and reserved sel.
module tb_eu_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  eu_responder_if #(.DW(32)) bus ();

  eu_responder #(.DW(32), .MUL_CYC(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state: what the outputs should currently hold.
  logic [31:0] m_result;
  logic [1:0]  m_flag;
  logic        m_ill;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [1:0]  flag;
    logic        we;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model: result/flags/illegal after one dispatched operation.
  function automatic void model_step(input logic [1:0] sel, input logic [31:0] ir_v,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output int lat, output logic we);
    logic [2:0]  f;
    logic [31:0] bb;
    lat = 2;
    we  = 1'b0;
    if (sel == 2'b10) begin
      m_flag = {a == b, $signed(a) < $signed(b)};
      return;
    end
    if (sel == 2'b11) begin
      m_ill = 1'b1;
      return;
    end
    f  = (sel == 2'b00) ? ir_v[20:18] : ir_v[2:0];
    bb = (sel == 2'b00) ? {{16{ir_v[15]}}, ir_v[15:0]} : b;
    if (f == 3'd7) begin
`ifdef EU_MUL_EN
      m_result = a * bb;
      lat      = 33;
      we       = 1'b1;
`else
      m_ill = 1'b1;
`endif
      return;
    end
    case (f)
      3'd0:    m_result = a + bb;
      3'd1:    m_result = a - bb;
      3'd2:    m_result = a & bb;
      3'd3:    m_result = a | bb;
      3'd4:    m_result = a ^ bb;
      3'd5:    m_result = a << bb[4:0];
      default: m_result = a >> bb[4:0];
    endcase
    we = 1'b1;
  endfunction

  // One dispatch. Called and returns at a negedge with the DUT idle.
  // mode 0: drop cs when ready seen; 1: hold cs 2 extra cycles;
  // mode 2: drop cs right after the latch edge.
  task automatic run_op(input logic [1:0] sel, input logic [31:0] ir_v,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [1:0] exp_flag,
                        input logic exp_we, input logic exp_ill,
                        input int lat, input int mode);
    int   we_cnt;
    logic early;
    logic hold_ok;
    // NOTE: inputs are driven with blocking assignments on the negedge.
    bus.cs_eu  = 1'b1;
    bus.sel_eu = sel;
    bus.ir     = ir_v;
    bus.op_a   = a;
    bus.op_b   = b;
    we_cnt  = 0;
    early   = 1'b0;
    hold_ok = 1'b1;
    for (int e = 1; e <= lat; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 1) begin
        bus.op_a   = $urandom;
        bus.op_b   = $urandom;
        bus.ir     = $urandom;
        bus.sel_eu = 2'($urandom);
        if (mode == 2) bus.cs_eu = 1'b0;
      end
      if (bus.result_we) we_cnt++;
      if (e < lat && bus.ready_eu) early = 1'b1;
    end
    check("ready_not_early", early, 1'b0);
    check("ready_at_latency", bus.ready_eu, 1'b1);
    if (mode == 1) begin
      for (int h = 0; h < 2; h++) begin
        @(posedge clk);
        @(negedge clk);
        if (bus.result_we) we_cnt++;
        if (!bus.ready_eu) hold_ok = 1'b0;
      end
      check("ready_held", hold_ok, 1'b1);
    end
    bus.cs_eu = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (bus.result_we) we_cnt++;
    check("ready_drop", bus.ready_eu, 1'b0);
    check("we_pulses", we_cnt, exp_we ? 1 : 0);
    check("result", bus.result, exp_res);
    check("flag", bus.Flag, exp_flag);
    check("illegal", bus.illegal, exp_ill);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sel;
    logic [31:0] ir_v, a, b;
    logic [2:0]  f;
    logic        we;
    int          lat;
    int          we_seen;

    tbl[0]  = '{2'b01, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 2'b00, 1'b1};
    tbl[1]  = '{2'b00, 32'h0004_FFFF, 32'h0000_0005, 32'h0000_DEAD, 32'h0000_0006, 2'b00, 1'b1};
    tbl[2]  = '{2'b01, 32'h0000_0005, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030, 2'b00, 1'b1};
    tbl[3]  = '{2'b10, 32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0030, 2'b01, 1'b0};
    tbl[4]  = '{2'b10, 32'h0000_0000, 32'h0000_0009, 32'h0000_0009, 32'h0000_0030, 2'b10, 1'b0};
    tbl[5]  = '{2'b01, 32'h0000_0002, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 2'b10, 1'b1};
    tbl[6]  = '{2'b01, 32'h0000_0003, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 2'b10, 1'b1};
    tbl[7]  = '{2'b01, 32'h0000_0004, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 2'b10, 1'b1};
    tbl[8]  = '{2'b01, 32'h0000_0006, 32'h8000_0000, 32'h0000_003F, 32'h0000_0001, 2'b10, 1'b1};
    tbl[9]  = '{2'b00, 32'h0000_7FFF, 32'h0000_0001, 32'h1234_5678, 32'h0000_8000, 2'b10, 1'b1};
    tbl[10] = '{2'b00, 32'h0004_8000, 32'h0000_0000, 32'h0000_0000, 32'h0000_8000, 2'b10, 1'b1};
    tbl[11] = '{2'b01, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 2'b10, 1'b1};
    tbl[12] = '{2'b10, 32'h0000_0007, 32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2'b00, 1'b0};
    tbl[13] = '{2'b00, 32'h0014_0021, 32'h4000_0001, 32'h0000_0000, 32'h8000_0002, 2'b00, 1'b1};

    // Reset held with cs_eu asserted: nothing may start.
    rst_n      = 1'b0;
    bus.cs_eu  = 1'b1;
    bus.sel_eu = 2'b01;
    bus.ir     = 32'h0;
    bus.op_a   = 32'h1;
    bus.op_b   = 32'h1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {bus.ready_eu, bus.result_we, bus.result, bus.Flag, bus.illegal}, '0);
    bus.cs_eu = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_after_reset", bus.ready_eu, 1'b0);

    // Directed table.
    for (int i = 0; i < 14; i++)
      run_op(tbl[i].sel, tbl[i].ir, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].flag,
             tbl[i].we, 1'b0, 2, i % 3);

    // Randomized ops against the model.
    m_result = tbl[13].res;
    m_flag   = tbl[13].flag;
    m_ill    = 1'b0;
    for (int n = 0; n < 200; n++) begin
      sel  = 2'($urandom_range(0, 2));
      ir_v = $urandom;
`ifdef EU_MUL_EN
      f = 3'($urandom_range(0, 7));
`else
      f = 3'($urandom_range(0, 6));
`endif
      if (sel == 2'b00) ir_v[20:18] = f;
      else              ir_v[2:0]   = f;
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? a : $urandom;
      model_step(sel, ir_v, a, b, lat, we);
      run_op(sel, ir_v, a, b, m_result, m_flag, we, m_ill, lat, n % 3);
    end

    // Reset in the middle of an operation: no write, back to reset values.
    bus.cs_eu  = 1'b1;
    bus.sel_eu = 2'b01;
`ifdef EU_MUL_EN
    bus.ir     = 32'h0000_0007;
`else
    bus.ir     = 32'h0000_0000;
`endif
    bus.op_a   = 32'h0001_2345;
    bus.op_b   = 32'h0000_0010;
    we_seen    = 0;
`ifdef EU_MUL_EN
    repeat (10) begin
`else
    repeat (1) begin
`endif
      @(posedge clk);
      @(negedge clk);
      if (bus.result_we) we_seen++;
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (bus.result_we) we_seen++;
    check("abort_outputs", {bus.ready_eu, bus.result_we, bus.result, bus.Flag, bus.illegal}, '0);
    bus.cs_eu = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.result_we) we_seen++;
    end
    check("abort_no_we", we_seen, 0);
    check("abort_idle", bus.ready_eu, 1'b0);
    m_result = 32'h0;
    m_flag   = 2'b00;
    m_ill    = 1'b0;

`ifdef EU_MUL_EN
    run_op(2'b01, 32'h0000_0007, 32'h0001_2345, 32'h0000_0010, 32'h0012_3450, 2'b00,
           1'b1, 1'b0, 33, 0);
    m_result = 32'h0012_3450;
`else
    run_op(2'b01, 32'h0000_0007, 32'h0000_0005, 32'h0000_0006, 32'h0, 2'b00,
           1'b0, 1'b1, 2, 0);
    m_ill = 1'b1;
`endif

    // Reserved class: illegal sticks, no write, 2-cycle handshake.
    run_op(2'b11, 32'h0000_0000, 32'h0000_0001, 32'h0000_0002, m_result, m_flag,
           1'b0, 1'b1, 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
